// File: rtl/sr_seq_pkg.sv
// sr_seq_pkg
//   Shared definitions for the SR latch command sequencer:
//   - state_t : sequencer FSM states (IDLE, SETUP, PULSE, HOLD, CHECK)
//   - CMD_SET / CMD_CLR : command encoding, also the level driven onto s
//   - clog2  : counter width helper (never returns less than 1)
package sr_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        CHECK = 3'd4
    } state_t;

    localparam logic CMD_SET = 1'b1;
    localparam logic CMD_CLR = 1'b0;

    // Bits needed to count 0..value-1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        int unsigned v;
        w = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/sr_cmd_sequencer_debounce.sv
// sr_debounce
//   Conditions one raw push-button input: 2-FF synchronizer, debounce
//   counter, and a one-cycle pulse on each 0->1 change of the debounced level.
//   Parameters:
//     DEB_CYCLES  consecutive cycles the synchronized input must differ from
//                 the debounced level before the level follows it (>=1)
//   Ports:
//     clk    in   clock, rising edge
//     rst_n  in   synchronous active-low reset
//     btn    in   raw button, asynchronous to clk
//     level  out  debounced level
//     rise   out  one-cycle pulse in the cycle level becomes 1
module sr_debounce
    import sr_seq_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int unsigned CNT_W = clog2(DEB_CYCLES);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
        end
    end

    // The count only advances while the synced input disagrees with the
    // current level; returning to agreement (a bounce) restarts it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (sync_q2 != level) begin
                if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
                    cnt   <= '0;
                    level <= sync_q2;
                    rise  <= sync_q2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/sr_cmd_sequencer.sv
// sr_cmd_sequencer
//   Upstream driver for a gated SR latch. Two noisy push-button requests
//   (set, clear) are debounced, held pending, and served one at a time as
//   clean s/r/e sequences: SETUP (s/r valid, e=0), PULSE (e=1 for
//   PULSE_CYCLES), HOLD (s/r valid, e=0), CHECK (done pulse). s and r are
//   never high together and e is only high while s/r are stable.
//   Configuration macro:
//     SR_SEQ_VERIFY_EN  defined: err pulses with done when q_fb != command
//                       undefined: err tied 0 (CHECK state still present)
//   Parameters:
//     DEB_CYCLES    debounce stability cycles (>=1)
//     PULSE_CYCLES  cycles e is held high per command (>=1)
//     CLR_PRIORITY  1: clear served first when both pending; 0: set first
//   Ports:
//     clk      in   clock, rising edge
//     rst_n    in   synchronous active-low reset
//     set_btn  in   raw set request (async)
//     clr_btn  in   raw clear request (async)
//     q_fb     in   latch q feedback
//     s, r, e  out  latch set / reset / enable
//     busy     out  command in flight (SETUP..CHECK)
//     done     out  one-cycle pulse in CHECK
//     err      out  one-cycle pulse in CHECK on q_fb mismatch
module sr_cmd_sequencer
    import sr_seq_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = 4,
    parameter int unsigned PULSE_CYCLES = 2,
    parameter int unsigned CLR_PRIORITY = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_btn,
    input  logic clr_btn,
    input  logic q_fb,
    output logic s,
    output logic r,
    output logic e,
    output logic busy,
    output logic done,
    output logic err
);

    localparam int unsigned PCNT_W = clog2(PULSE_CYCLES);

    state_t            state;
    logic              cmd;
    logic [PCNT_W-1:0] pcnt;
    logic              pend_set;
    logic              pend_clr;

    logic              set_level;
    logic              set_rise;
    logic              clr_level;
    logic              clr_rise;

    logic              pick;
    logic              take_set;
    logic              take_clr;

    sr_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb_set (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (set_btn),
        .level (set_level),
        .rise  (set_rise)
    );

    sr_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb_clr (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (clr_btn),
        .level (clr_level),
        .rise  (clr_rise)
    );

    // Levels are only needed for the rise pulse inside the debouncer.
    logic unused_levels;
    assign unused_levels = set_level ^ clr_level;

    // Arbitration in IDLE: only the chosen flag is consumed.
    always_comb begin
        pick     = CMD_CLR;
        take_set = 1'b0;
        take_clr = 1'b0;
        if (state == IDLE) begin
            if (pend_set && pend_clr) begin
                pick = (CLR_PRIORITY != 0) ? CMD_CLR : CMD_SET;
            end else if (pend_set) begin
                pick = CMD_SET;
            end else begin
                pick = CMD_CLR;
            end
            if (pend_set || pend_clr) begin
                take_set = (pick == CMD_SET);
                take_clr = (pick == CMD_CLR);
            end
        end
    end

    // Outputs are registered alongside the state so each output reflects the
    // state being entered; a request pulse in the cycle its flag is consumed
    // re-arms the flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cmd      <= CMD_CLR;
            pcnt     <= '0;
            pend_set <= 1'b0;
            pend_clr <= 1'b0;
            s        <= 1'b0;
            r        <= 1'b0;
            e        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            pend_set <= (pend_set & ~take_set) | set_rise;
            pend_clr <= (pend_clr & ~take_clr) | clr_rise;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (pend_set || pend_clr) begin
                        state <= SETUP;
                        cmd   <= pick;
                        s     <= pick;
                        r     <= ~pick;
                        e     <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                SETUP: begin
                    state <= PULSE;
                    e     <= 1'b1;
                    pcnt  <= '0;
                end
                PULSE: begin
                    if (pcnt == PCNT_W'(PULSE_CYCLES - 1)) begin
                        state <= HOLD;
                        e     <= 1'b0;
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                end
                HOLD: begin
                    state <= CHECK;
                    s     <= 1'b0;
                    r     <= 1'b0;
                    done  <= 1'b1;
                end
                CHECK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    s     <= 1'b0;
                    r     <= 1'b0;
                    e     <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SR_SEQ_VERIFY_EN
    // q_fb is sampled during HOLD so err lines up with done in CHECK.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= (state == HOLD) && (q_fb != cmd);
        end
    end
`else
    logic unused_q_fb;
    assign unused_q_fb = q_fb;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
module tb_sr_cmd_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic set_btn;
    logic clr_btn;
    logic q_fb;
    logic s, r, e, busy, done, err;

    int checks = 0;
    int errors = 0;
    int lat;

    // Gated SR latch model; q_stuck forces the feedback low.
    logic latch_q = 1'b0;
    logic q_stuck = 1'b0;
    always @(posedge clk) if (e === 1'b1) latch_q <= s;
    assign q_fb = q_stuck ? 1'b0 : latch_q;

    logic [5:0] obs_s, obs_r, obs_e, obs_busy, obs_done, obs_err, obs_sr;

`ifdef SR_SEQ_VERIFY_EN
    localparam logic [5:0] EXP_STUCK_ERR = 6'b010000;
`else
    localparam logic [5:0] EXP_STUCK_ERR = 6'b000000;
`endif

    always #5 clk = ~clk;

    sr_cmd_sequencer #(
        .DEB_CYCLES   (4),
        .PULSE_CYCLES (2),
        .CLR_PRIORITY (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_btn (set_btn),
        .clr_btn (clr_btn),
        .q_fb    (q_fb),
        .s       (s),
        .r       (r),
        .e       (e),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Records 6 cycles starting now (bit i = cycle i after SETUP entry).
    task automatic capture;
        for (int i = 0; i < 6; i++) begin
            obs_s[i]    = s;
            obs_r[i]    = r;
            obs_e[i]    = e;
            obs_busy[i] = busy;
            obs_done[i] = done;
            obs_err[i]  = err;
            obs_sr[i]   = s & r;
            if (i < 5) tick();
        end
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (busy !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; set_btn = 1'b1; clr_btn = 1'b0; q_stuck = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({s, r, e, busy, done, err} !== 6'b000000)
                $display("FAIL reset_outputs got %b want 000000", {s, r, e, busy, done, err});
        end
        rst_n = 1'b1;
        wait_busy(lat);
        checks++;
        if (lat !== 8) $display("FAIL reset_release_latency got %0d want 8", lat);
        if (lat !== 8) errors++;
        capture();
        checks++;
        if (obs_s !== 6'b001111) begin errors++; $display("FAIL reset_seq_s got %b want 001111", obs_s); end
        checks++;
        if (obs_e !== 6'b000110) begin errors++; $display("FAIL reset_seq_e got %b want 000110", obs_e); end
        set_btn = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_clean_set;
        int extra;
        set_btn = 1'b1;
        wait_busy(lat);
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL set_latency got %0d want 8", lat); end
        capture();
        checks++;
        if (obs_s !== 6'b001111) begin errors++; $display("FAIL set_s got %b want 001111", obs_s); end
        checks++;
        if (obs_r !== 6'b000000) begin errors++; $display("FAIL set_r got %b want 000000", obs_r); end
        checks++;
        if (obs_e !== 6'b000110) begin errors++; $display("FAIL set_e got %b want 000110", obs_e); end
        checks++;
        if (obs_busy !== 6'b011111) begin errors++; $display("FAIL set_busy got %b want 011111", obs_busy); end
        checks++;
        if (obs_done !== 6'b010000) begin errors++; $display("FAIL set_done got %b want 010000", obs_done); end
        checks++;
        if (obs_err !== 6'b000000) begin errors++; $display("FAIL set_err got %b want 000000", obs_err); end
        checks++;
        if (q_fb !== 1'b1) begin errors++; $display("FAIL set_latch_q got %b want 1", q_fb); end
        extra = 0;
        repeat (15) begin tick(); if (busy !== 1'b0) extra++; end
        set_btn = 1'b0;
        repeat (12) begin tick(); if (busy !== 1'b0) extra++; end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL set_single_seq got %0d busy cycles want 0", extra); end
    endtask

    task automatic test_bounce;
        int act;
        act = 0;
        for (int i = 0; i < 10; i++) begin
            set_btn = (i % 2 == 0);
            repeat (2) begin tick(); if ({s, r, e, busy} !== 4'b0000) act++; end
        end
        set_btn = 1'b0;
        repeat (12) begin tick(); if ({s, r, e, busy} !== 4'b0000) act++; end
        checks++;
        if (act !== 0) begin errors++; $display("FAIL bounce_activity got %0d active cycles want 0", act); end
    endtask

    task automatic test_simultaneous;
        set_btn = 1'b1; clr_btn = 1'b1;
        wait_busy(lat);
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL simul_latency got %0d want 8", lat); end
        capture();
        checks++;
        if (obs_r !== 6'b001111 || obs_s !== 6'b000000) begin
            errors++; $display("FAIL simul_first_clr got s=%b r=%b want s=000000 r=001111", obs_s, obs_r);
        end
        checks++;
        if (obs_busy !== 6'b011111) begin errors++; $display("FAIL simul_idle_gap got %b want 011111", obs_busy); end
        tick();
        capture();
        checks++;
        if (obs_s !== 6'b001111 || obs_r !== 6'b000000) begin
            errors++; $display("FAIL simul_second_set got s=%b r=%b want s=001111 r=000000", obs_s, obs_r);
        end
        checks++;
        if (obs_done !== 6'b010000) begin errors++; $display("FAIL simul_second_done got %b want 010000", obs_done); end
        set_btn = 1'b0; clr_btn = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_busy_overlap;
        logic [5:0] sr_acc;
        set_btn = 1'b1;
        repeat (3) tick();
        clr_btn = 1'b1;
        wait_busy(lat);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL overlap_latency got %0d want 5", lat); end
        capture();
        sr_acc = obs_sr;
        checks++;
        if (obs_s !== 6'b001111 || obs_busy !== 6'b011111) begin
            errors++; $display("FAIL overlap_set got s=%b busy=%b want s=001111 busy=011111", obs_s, obs_busy);
        end
        tick();
        capture();
        sr_acc = sr_acc | obs_sr;
        checks++;
        if (obs_r !== 6'b001111 || obs_e !== 6'b000110) begin
            errors++; $display("FAIL overlap_clr got r=%b e=%b want r=001111 e=000110", obs_r, obs_e);
        end
        checks++;
        if (sr_acc !== 6'b000000) begin errors++; $display("FAIL overlap_s_and_r got %b want 000000", sr_acc); end
        set_btn = 1'b0; clr_btn = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_verify_abort;
        int act;
        q_stuck = 1'b1;
        set_btn = 1'b1;
        wait_busy(lat);
        capture();
        checks++;
        if (obs_done !== 6'b010000) begin errors++; $display("FAIL verify_done got %b want 010000", obs_done); end
        checks++;
        if (obs_err !== EXP_STUCK_ERR) begin errors++; $display("FAIL verify_err got %b want %b", obs_err, EXP_STUCK_ERR); end
        set_btn = 1'b0; q_stuck = 1'b0;
        repeat (12) tick();
        set_btn = 1'b1;
        wait_busy(lat);
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL abort_latency got %0d want 8", lat); end
        tick();
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL abort_in_pulse got e=%b want 1", e); end
        rst_n = 1'b0; set_btn = 1'b0;
        tick();
        checks++;
        if ({s, r, e, busy, done, err} !== 6'b000000) begin
            errors++; $display("FAIL abort_outputs got %b want 000000", {s, r, e, busy, done, err});
        end
        rst_n = 1'b1;
        act = 0;
        repeat (15) begin tick(); if ({done, busy, e} !== 3'b000) act++; end
        checks++;
        if (act !== 0) begin errors++; $display("FAIL abort_no_done got %0d active cycles want 0", act); end
    endtask

    initial begin
        test_reset();
        if (checks > 0 && (s & r) === 1'b1) errors++;
        test_clean_set();
        test_bounce();
        test_simultaneous();
        test_busy_overlap();
        test_verify_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // The first reset checks count their failures here so the tally is exact.
    always @(negedge clk) begin
        if (rst_n === 1'b0 && checks < 3 && {s, r, e, busy, done, err} !== 6'b000000 && $time > 10)
            errors++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1);
    end

endmodule
